// File: rtl/rv32i_types.sv
// Shared execute-stage types: iterative ALU op codes and FSM states.
package rv32i_types;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SLL    = 5'd1,
    OP_SRA    = 5'd2,
    OP_SUB    = 5'd3,
    OP_XOR    = 5'd4,
    OP_SRL    = 5'd5,
    OP_OR     = 5'd6,
    OP_AND    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } iter_alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } iter_alu_state_t;

endpackage

// File: rtl/iter_muldiv_core.sv
// Unsigned iterative engine: one shift-add multiply or restoring-divide step per cycle.
// Outputs are the post-step values so the parent can capture the final step directly.
module iter_muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a_mag,
  input  logic [WIDTH-1:0] i_b_mag,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_op2;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_fits;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

  // Multiply: r_lo holds the multiplier, shifted out as the product fills in.
  // Divide: r_lo holds the dividend, shifted into r_hi while quotient bits enter r_lo.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op2} : '0);
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_fits  = (w_shift >= {1'b0, r_op2});
  assign w_diff  = w_shift[WIDTH-1:0] - r_op2;

  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_is_div) begin
      w_hi_nxt = w_fits ? w_diff : w_shift[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], w_fits};
    end else begin
      w_hi_nxt = w_sum[WIDTH:1];
      w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_op2    <= '0;
    end else if (i_abort) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt    <= CW'(WIDTH);
      r_is_div <= i_is_div;
      r_hi     <= '0;
      r_lo     <= i_is_div ? i_a_mag : i_b_mag;
      r_op2    <= i_is_div ? i_b_mag : i_a_mag;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
    end
  end

  assign o_done = (r_cnt == CW'(1));
  assign o_hi   = w_hi_nxt;
  assign o_lo   = w_lo_nxt;
  assign o_quot = w_lo_nxt;
  assign o_rem  = w_hi_nxt;

endmodule

// File: rtl/iter_alu.sv
// Execute-stage ALU with iterative RV32M mul/div behind a valid/ready request/response handshake.
// Handshake: a request is taken when req_valid & req_ready & ~flush; a response is consumed when resp_valid & resp_ready.
module iter_alu
  import rv32i_types::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [4:0]            req_op,
  input  logic [WIDTH-1:0]      req_a,
  input  logic [WIDTH-1:0]      req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH-1:0]      resp_f,
  output logic                  busy,
  output iter_alu_state_t       dbg_state
);

  iter_alu_state_t r_state, w_state_next;
  logic [WIDTH-1:0] r_resp_f;
  logic [4:0]       r_op;
  logic             r_neg;

  logic [WIDTH-1:0]   w_min;
  logic [SHAMT_W-1:0] w_shamt;
  logic w_accept, w_fast, w_is_muldiv, w_is_div, w_b_zero, w_ovf;
  logic w_a_neg, w_b_neg, w_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_fast_res, w_slow_res;
  logic w_core_done;
  logic [WIDTH-1:0] w_hi, w_lo, w_quot, w_rem;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;

  assign w_min       = {1'b1, {(WIDTH-1){1'b0}}};
  assign w_shamt     = req_b[SHAMT_W-1:0];
  assign w_is_muldiv = (req_op >= OP_MUL) && (req_op <= OP_REMU);
  assign w_is_div    = (req_op >= OP_DIV) && (req_op <= OP_REMU);
  assign w_b_zero    = (req_b == '0);
  assign w_ovf       = ((req_op == OP_DIV) || (req_op == OP_REM)) && (req_a == w_min) && (req_b == '1);
  assign w_fast      = !w_is_muldiv || (w_is_div && (w_b_zero || w_ovf));
  assign w_accept    = req_valid && req_ready && !flush;

  // Signedness: mulh/div/rem both signed, mulhsu only a, everything else unsigned.
  assign w_a_neg = req_a[WIDTH-1] && ((req_op == OP_MULH) || (req_op == OP_MULHSU) ||
                                      (req_op == OP_DIV)  || (req_op == OP_REM));
  assign w_b_neg = req_b[WIDTH-1] && ((req_op == OP_MULH) || (req_op == OP_DIV) || (req_op == OP_REM));
  assign w_a_mag = w_a_neg ? -req_a : req_a;
  assign w_b_mag = w_b_neg ? -req_b : req_b;
  assign w_neg   = (req_op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

  always_comb begin
    w_fast_res = '0;
    case (req_op)
      OP_ADD:  w_fast_res = req_a + req_b;
      OP_SLL:  w_fast_res = req_a << w_shamt;
      OP_SRA:  w_fast_res = $signed(req_a) >>> w_shamt;
      OP_SUB:  w_fast_res = req_a - req_b;
      OP_XOR:  w_fast_res = req_a ^ req_b;
      OP_SRL:  w_fast_res = req_a >> w_shamt;
      OP_OR:   w_fast_res = req_a | req_b;
      OP_AND:  w_fast_res = req_a & req_b;
      OP_SLT:  w_fast_res = {{(WIDTH-1){1'b0}}, ($signed(req_a) < $signed(req_b))};
      OP_SLTU: w_fast_res = {{(WIDTH-1){1'b0}}, (req_a < req_b)};
      OP_DIV, OP_DIVU: w_fast_res = w_b_zero ? '1 : req_a;
      OP_REM, OP_REMU: w_fast_res = w_b_zero ? req_a : '0;
      default: w_fast_res = '0;
    endcase
  end

  iter_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_accept && !w_fast),
    .i_abort (flush),
    .i_is_div(w_is_div),
    .i_a_mag (w_a_mag),
    .i_b_mag (w_b_mag),
    .o_done  (w_core_done),
    .o_hi    (w_hi),
    .o_lo    (w_lo),
    .o_quot  (w_quot),
    .o_rem   (w_rem)
  );

  assign w_prod     = {w_hi, w_lo};
  assign w_prod_fix = r_neg ? -w_prod : w_prod;

  always_comb begin
    w_slow_res = '0;
    case (r_op)
      OP_MUL:                        w_slow_res = w_prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  w_slow_res = w_prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:               w_slow_res = r_neg ? -w_quot : w_quot;
      OP_REM, OP_REMU:               w_slow_res = r_neg ? -w_rem : w_rem;
      default:                       w_slow_res = '0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (req_valid) w_state_next = w_fast ? DONE : CALC;
        CALC:    if (w_core_done) w_state_next = DONE;
        DONE:    if (resp_ready) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_f <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
    end else if (w_accept) begin
      r_op  <= req_op;
      r_neg <= w_neg;
      if (w_fast) r_resp_f <= w_fast_res;
    end else if ((r_state == CALC) && w_core_done && !flush) begin
      r_resp_f <= w_slow_res;
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == DONE);
  assign busy       = (r_state != IDLE);
  assign resp_f     = r_resp_f;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_iter_alu.sv
// Bench for iter_alu: directed and random ops on a 32-bit and an 8-bit instance,
// checked against an arithmetic reference model.
module tb_iter_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        sel8 = 1'b0;
  logic        tb_valid = 1'b0;
  logic        tb_rready = 1'b0;
  logic [4:0]  tb_op = '0;
  logic [31:0] tb_a = '0;
  logic [31:0] tb_b = '0;

  logic        req_ready32, resp_valid32, busy32;
  logic [31:0] resp_f32;
  logic [1:0]  dbg32;
  logic        req_ready8, resp_valid8, busy8;
  logic [7:0]  resp_f8;
  logic [1:0]  dbg8;

  logic        o_valid, o_rready, o_busy;
  logic [31:0] o_f;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  iter_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(tb_valid && !sel8), .req_ready(req_ready32),
    .req_op(tb_op), .req_a(tb_a), .req_b(tb_b),
    .resp_valid(resp_valid32), .resp_ready(tb_rready && !sel8),
    .resp_f(resp_f32), .busy(busy32), .dbg_state(dbg32)
  );

  iter_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(tb_valid && sel8), .req_ready(req_ready8),
    .req_op(tb_op), .req_a(tb_a[7:0]), .req_b(tb_b[7:0]),
    .resp_valid(resp_valid8), .resp_ready(tb_rready && sel8),
    .resp_f(resp_f8), .busy(busy8), .dbg_state(dbg8)
  );

  always_comb begin
    o_valid  = sel8 ? resp_valid8 : resp_valid32;
    o_rready = sel8 ? req_ready8  : req_ready32;
    o_busy   = sel8 ? busy8       : busy32;
    o_f      = sel8 ? {24'b0, resp_f8} : resp_f32;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Result of one op on w-bit operands, from the RV32M definitions.
  function automatic logic [31:0] model(input int op, input logic [31:0] a, input logic [31:0] b, input int w);
    longint half, ua, ub, sa, sb, r;
    longint unsigned pu;
    logic [63:0] rr;
    logic [31:0] mask;
    int sh;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    half = longint'(1) <<< (w - 1);
    ua = longint'(a & mask);
    ub = longint'(b & mask);
    sa = (ua >= half) ? ua - 2 * half : ua;
    sb = (ub >= half) ? ub - 2 * half : ub;
    sh = int'(ub % longint'(w));
    r = 0;
    case (op)
      0:  r = ua + ub;
      1:  r = ua << sh;
      2:  r = sa >>> sh;
      3:  r = ua - ub;
      4:  r = ua ^ ub;
      5:  r = ua >> sh;
      6:  r = ua | ub;
      7:  r = ua & ub;
      8:  r = (sa < sb) ? 1 : 0;
      9:  r = (ua < ub) ? 1 : 0;
      10: r = ua * ub;
      11: r = (sa * sb) >>> w;
      12: r = (sa * ub) >>> w;
      13: begin pu = $unsigned(ua) * $unsigned(ub); r = longint'(pu >> w); end
      14: r = (ub == 0) ? -1 : ((sa == -half && sb == -1) ? ua : sa / sb);
      15: r = (ub == 0) ? -1 : ua / ub;
      16: r = (ub == 0) ? ua : ((sa == -half && sb == -1) ? 0 : sa % sb);
      17: r = (ub == 0) ? ua : ua % ub;
      default: r = 0;
    endcase
    rr = r;
    return rr[31:0] & mask;
  endfunction

  function automatic int exp_lat(input int op, input logic [31:0] a, input logic [31:0] b, input int w);
    logic [31:0] mask, minv;
    logic        bz, ovf;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    minv = (w == 32) ? 32'h8000_0000 : 32'h0000_0080;
    bz   = ((b & mask) == 0);
    ovf  = (op == 14 || op == 16) && ((a & mask) == minv) && ((b & mask) == mask);
    if (op < 10 || op > 17) return 1;
    if (op >= 14 && (bz || ovf)) return 1;
    return w + 1;
  endfunction

  // Issue one op, measure latency, check the result, hold it under backpressure, release it.
  task automatic run_op(input int w, input int op, input logic [31:0] a, input logic [31:0] b, input int hold);
    int lat;
    int want_lat;
    logic [31:0] want;
    sel8     = (w == 8);
    want_lat = exp_lat(op, a, b, w);
    exp_q.push_back(model(op, a, b, w));
    tb_op    = 5'(op);
    tb_a     = a;
    tb_b     = b;
    tb_valid = 1'b1;
    @(posedge clk); #1;
    tb_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    want = exp_q.pop_front();
    check($sformatf("lat w%0d op%0d", w, op), 32'(lat), 32'(want_lat));
    check($sformatf("res w%0d op%0d a=%h b=%h", w, op, a, b), o_f, want);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_f", o_f, want);
      check("hold_rdy", {31'b0, o_rready}, 32'd0);
    end
    tb_rready = 1'b1;
    @(posedge clk); #1;
    tb_rready = 1'b0;
    check("back_idle", {31'b0, o_busy}, 32'd0);
  endtask

  initial begin
    int seen;
    int op;
    logic [31:0] a, b;

    #1 rst = 1'b1;
    #20;
    check("rst_valid32", {31'b0, resp_valid32}, 32'd0);
    check("rst_ready32", {31'b0, req_ready32}, 32'd1);
    check("rst_busy32", {31'b0, busy32}, 32'd0);
    check("rst_f32", resp_f32, 32'd0);
    check("rst_state32", {30'b0, dbg32}, 32'd0);
    check("rst_f8", {24'b0, resp_f8}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(32, 0,  32'hFFFF_FFFF, 32'h1, 0);
    run_op(32, 2,  32'h8000_0000, 32'h24, 0);
    run_op(32, 11, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(32, 13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(32, 14, 32'hFFFF_FFF9, 32'h2, 0);
    run_op(32, 16, 32'hFFFF_FFF9, 32'h2, 0);
    run_op(32, 15, 32'h7, 32'h0, 0);
    run_op(32, 14, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(32, 16, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(32, 17, 32'h1234, 32'h0, 0);
    run_op(32, 20, 32'h5, 32'h6, 0);
    run_op(32, 3,  32'h0, 32'h1, 5);
    run_op(32, 12, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);

    // Flush on the tenth CALC cycle of a divu: no response, back to IDLE.
    sel8 = 1'b0; tb_op = 5'd15; tb_a = 32'hDEAD_BEEF; tb_b = 32'h3; tb_valid = 1'b1;
    @(posedge clk); #1;
    tb_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_ready", {31'b0, req_ready32}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid32) seen++;
    end
    check("flush_noresp", 32'(seen), 32'd0);
    run_op(32, 0, 32'h1111_1111, 32'h2222_2222, 0);

    // A request alongside flush must be ignored.
    tb_op = 5'd0; tb_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    tb_valid = 1'b0; flush = 1'b0;
    check("flush_blocks_accept", {31'b0, busy32}, 32'd0);

    // Asynchronous reset between edges in the middle of a multiply.
    tb_op = 5'd10; tb_a = 32'h1234_5678; tb_b = 32'h9ABC_DEF0; tb_valid = 1'b1;
    @(posedge clk); #1;
    tb_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'b0, busy32}, 32'd0);
    check("arst_ready", {31'b0, req_ready32}, 32'd1);
    check("arst_valid", {31'b0, resp_valid32}, 32'd0);
    check("arst_f", resp_f32, 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    run_op(8, 10, 32'h10, 32'h10, 0);
    run_op(8, 13, 32'h10, 32'h10, 0);
    run_op(8, 14, 32'h80, 32'hFF, 0);
    run_op(8, 11, 32'h80, 32'h80, 2);

    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 21));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      run_op(32, op, a, b, int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < 30; i++) begin
      op = int'($urandom_range(0, 19));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 4) == 0) b = 32'h0;
      run_op(8, op, a, b, int'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
